// File: rtl/ram_phase_sched_pkg.sv
// Shared types and phase-position helpers for the single-clock phase scheduler.
// Every phase position is derived from the CPU period exponent DIV_LOG2.
package ram_phase_sched_pkg;

  typedef enum logic [0:0] {
    SLOT_CPU = 1'b0,
    SLOT_AUX = 1'b1
  } owner_e;

  function automatic int ph_n(input int div_log2);
    return 32'sd1 << div_log2;
  endfunction

  // Phase in which the RAM read data is sampled.
  function automatic int ph_ram(input int div_log2);
    return ph_n(div_log2) / 32'sd2 - 32'sd1;
  endfunction

  function automatic int win_lo(input int div_log2);
    return ph_n(div_log2) / 32'sd4;
  endfunction

  function automatic int win_hi(input int div_log2);
    return (32'sd3 * ph_n(div_log2)) / 32'sd4 - 32'sd1;
  endfunction

endpackage

// File: rtl/ram_phase_sched_phase_ctr.sv
// Free-running wrapping phase counter with synchronous active-low clear.
// It also exposes the next count and a registered terminal-count flag.
module ram_phase_sched_phase_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         tc
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] LAST = {W{1'b1}};

  // The period is a power of two, so natural overflow is the wrap.
  always_comb begin
    count_next = count + ONE;
  end

  // Counter and terminal-count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
      tc    <= 1'b0;
    end else begin
      count <= count_next;
      tc    <= (count_next == LAST);
    end
  end

endmodule

// File: rtl/ram_phase_sched.sv
// Phase scheduler: one-cycle CPU/RAM/pixel enables, a registered RAM write window,
// and a fair CPU/aux owner FSM for the single RAM port. All outputs are registers.
module ram_phase_sched
  import ram_phase_sched_pkg::*;
#(
  parameter int DIV_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_we,
  input  logic                aux_req,
  input  logic                aux_we,
  output logic                cpu_ce,
  output logic                ram_ce,
  output logic                ram_we,
  output logic                ram_sel,
  output logic                aux_ack,
  output logic                pix_ce,
  output logic [DIV_LOG2-1:0] phase
);

  localparam logic [DIV_LOG2-1:0] PH_ZERO = {DIV_LOG2{1'b0}};
  localparam logic [DIV_LOG2-1:0] PH_LAST = {DIV_LOG2{1'b1}};
  localparam logic [DIV_LOG2-1:0] PH_RAM  = DIV_LOG2'(ph_ram(DIV_LOG2));
  localparam logic [DIV_LOG2-1:0] WIN_LO  = DIV_LOG2'(win_lo(DIV_LOG2));
  localparam logic [DIV_LOG2-1:0] WIN_HI  = DIV_LOG2'(win_hi(DIV_LOG2));

  logic [DIV_LOG2-1:0] phase_next;
  logic                tc;

  owner_e state;
  owner_e state_next;
  logic   last_aux;
  logic   last_aux_next;
  logic   slot_we;
  logic   slot_we_next;

  logic cpu_ce_next;
  logic ram_ce_next;
  logic ram_we_next;
  logic ram_sel_next;
  logic aux_ack_next;

  ram_phase_sched_phase_ctr #(
    .W (DIV_LOG2)
  ) u_phase_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .count      (phase),
    .count_next (phase_next),
    .tc         (tc)
  );

  // Owner next-state, fairness flag, write latch and next-cycle output decode.
  always_comb begin
    state_next    = state;
    last_aux_next = last_aux;
    slot_we_next  = slot_we;

    if (tc) begin
      case (state)
        SLOT_CPU: begin
          if (aux_req && !last_aux) begin
            state_next = SLOT_AUX;
          end else begin
            state_next = SLOT_CPU;
          end
        end
        SLOT_AUX: state_next = SLOT_CPU;
        default:  state_next = SLOT_CPU;
      endcase
      last_aux_next = (state_next == SLOT_AUX);
    end else begin
      state_next    = state;
      last_aux_next = last_aux;
    end

    // The slot owner is fixed during phase 0, so its write request is latched there.
    if (phase == PH_ZERO) begin
      slot_we_next = (state == SLOT_AUX) ? aux_we : cpu_we;
    end else begin
      slot_we_next = slot_we;
    end

    // Outputs are registered, so decode against the state the next cycle will hold.
    cpu_ce_next  = (phase_next == PH_LAST) && (state_next == SLOT_CPU);
    aux_ack_next = (phase_next == PH_LAST) && (state_next == SLOT_AUX);
    ram_ce_next  = (phase_next == PH_RAM);
    ram_sel_next = (state_next == SLOT_AUX);
    ram_we_next  = slot_we_next && (phase_next >= WIN_LO) && (phase_next <= WIN_HI);
  end

  // Owner state, fairness flag and latched slot write request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SLOT_CPU;
      last_aux <= 1'b0;
      slot_we  <= 1'b0;
    end else begin
      state    <= state_next;
      last_aux <= last_aux_next;
      slot_we  <= slot_we_next;
    end
  end

  // Output registers; pix_ce toggles independently of the slot schedule.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_ce  <= 1'b0;
      ram_ce  <= 1'b0;
      ram_we  <= 1'b0;
      ram_sel <= 1'b0;
      aux_ack <= 1'b0;
      pix_ce  <= 1'b0;
    end else begin
      cpu_ce  <= cpu_ce_next;
      ram_ce  <= ram_ce_next;
      ram_we  <= ram_we_next;
      ram_sel <= ram_sel_next;
      aux_ack <= aux_ack_next;
      pix_ce  <= ~pix_ce;
    end
  end

endmodule

// File: tb/tb_ram_phase_sched.sv
// Directed bench for ram_phase_sched: a default instance (N=4) and a DIV_LOG2=4 instance
// share clock and reset; outputs are sampled on the falling edge.
module tb_ram_phase_sched;

  logic       clk;
  logic       rst_n;
  logic       cpu_we;
  logic       aux_req;
  logic       aux_we;
  logic       cpu_ce;
  logic       ram_ce;
  logic       ram_we;
  logic       ram_sel;
  logic       aux_ack;
  logic       pix_ce;
  logic [1:0] phase;

  logic       cpu_we4;
  logic       aux_req4;
  logic       aux_we4;
  logic       cpu_ce4;
  logic       ram_ce4;
  logic       ram_we4;
  logic       ram_sel4;
  logic       aux_ack4;
  logic       pix_ce4;
  logic [3:0] phase4;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;

  ram_phase_sched #(.DIV_LOG2(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_we  (cpu_we),
    .aux_req (aux_req),
    .aux_we  (aux_we),
    .cpu_ce  (cpu_ce),
    .ram_ce  (ram_ce),
    .ram_we  (ram_we),
    .ram_sel (ram_sel),
    .aux_ack (aux_ack),
    .pix_ce  (pix_ce),
    .phase   (phase)
  );

  ram_phase_sched #(.DIV_LOG2(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_we  (cpu_we4),
    .aux_req (aux_req4),
    .aux_we  (aux_we4),
    .cpu_ce  (cpu_ce4),
    .ram_ce  (ram_ce4),
    .ram_we  (ram_we4),
    .ram_sel (ram_sel4),
    .aux_ack (aux_ack4),
    .pix_ce  (pix_ce4),
    .phase   (phase4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s c%0d: observed %0d expected %0d", tag, cyc, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int p;
    logic aux_slot;

    rst_n    = 1'b0;
    cpu_we   = 1'b1;
    aux_req  = 1'b0;
    aux_we   = 1'b0;
    cpu_we4  = 1'b1;
    aux_req4 = 1'b0;
    aux_we4  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    cyc = 0;
    check("rst_phase",   32'(phase),   32'd0);
    check("rst_cpu_ce",  32'(cpu_ce),  32'd0);
    check("rst_ram_ce",  32'(ram_ce),  32'd0);
    check("rst_ram_we",  32'(ram_we),  32'd0);
    check("rst_ram_sel", 32'(ram_sel), 32'd0);
    check("rst_aux_ack", 32'(aux_ack), 32'd0);
    check("rst_pix_ce",  32'(pix_ce),  32'd0);
    rst_n = 1'b1;

    // Reset release and steady CPU writes: cycles 0..11.
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      p = c % 4;
      check("t1_phase",   32'(phase),   32'(p));
      check("t1_cpu_ce",  32'(cpu_ce),  32'(p == 3));
      check("t1_ram_ce",  32'(ram_ce),  32'(p == 1));
      check("t1_pix_ce",  32'(pix_ce),  32'(c % 2));
      check("t1_ram_we",  32'(ram_we),  32'(p == 1 || p == 2));
      check("t1_ram_sel", 32'(ram_sel), 32'd0);
      check("t1_aux_ack", 32'(aux_ack), 32'd0);
    end

    // Single aux request raised at phase 2 of the slot starting at cycle 12.
    step();
    step();
    step();
    check("t3_pre_ram_we", 32'(ram_we), 32'd1);
    cpu_we  = 1'b0;
    aux_req = 1'b1;
    aux_we  = 1'b1;
    for (int c = 15; c < 24; c++) begin
      step();
      p = c % 4;
      aux_slot = (c >= 16) && (c <= 19);
      check("t3_phase",   32'(phase),   32'(p));
      check("t3_ram_sel", 32'(ram_sel), 32'(aux_slot));
      check("t3_ram_we",  32'(ram_we),  32'(aux_slot && (p == 1 || p == 2)));
      check("t3_cpu_ce",  32'(cpu_ce),  32'(!aux_slot && p == 3));
      check("t3_aux_ack", 32'(aux_ack), 32'(c == 19));
      if (c == 19) aux_req = 1'b0;
      if (c == 22) aux_req = 1'b1;
    end

    // Continuous aux request: AUX and CPU slots alternate from cycle 24.
    for (int c = 24; c < 42; c++) begin
      step();
      p = c % 4;
      aux_slot = (((c - 24) / 4) % 2) == 0;
      check("t4_phase",   32'(phase),   32'(p));
      check("t4_ram_sel", 32'(ram_sel), 32'(aux_slot));
      check("t4_aux_ack", 32'(aux_ack), 32'(aux_slot && p == 3));
      check("t4_cpu_ce",  32'(cpu_ce),  32'(!aux_slot && p == 3));
      check("t4_ram_we",  32'(ram_we),  32'(aux_slot && (p == 1 || p == 2)));
    end

    // Reset at phase 1 of the aux slot starting at cycle 40.
    rst_n = 1'b0;
    step();
    cyc = 0;
    check("t5_phase",   32'(phase),   32'd0);
    check("t5_ram_sel", 32'(ram_sel), 32'd0);
    check("t5_ram_we",  32'(ram_we),  32'd0);
    check("t5_aux_ack", 32'(aux_ack), 32'd0);
    check("t5_cpu_ce",  32'(cpu_ce),  32'd0);
    check("t5_pix_ce",  32'(pix_ce),  32'd0);
    check("t5_phase4",  32'(phase4),  32'd0);
    rst_n   = 1'b1;
    aux_req = 1'b1;

    // Request dropped before phase 3 is never granted.
    for (int c = 1; c < 8; c++) begin
      step();
      if (c == 1) aux_req = 1'b0;
      p = c % 4;
      check("t5_phase",   32'(phase),   32'(p));
      check("t5_ram_sel", 32'(ram_sel), 32'd0);
      check("t5_aux_ack", 32'(aux_ack), 32'd0);
      check("t5_cpu_ce",  32'(cpu_ce),  32'(p == 3));
      check("t5_ram_we",  32'(ram_we),  32'd0);
    end

    // DIV_LOG2=4 instance, counted from the same reset.
    while (cyc < 15) step();
    for (int c = 16; c < 48; c++) begin
      step();
      p = c % 16;
      check("t6_phase4",   32'(phase4),   32'(p));
      check("t6_cpu_ce4",  32'(cpu_ce4),  32'(p == 15));
      check("t6_ram_ce4",  32'(ram_ce4),  32'(p == 7));
      check("t6_ram_we4",  32'(ram_we4),  32'(p >= 4 && p <= 11));
      check("t6_ram_sel4", 32'(ram_sel4), 32'd0);
      check("t6_aux_ack4", 32'(aux_ack4), 32'd0);
      check("t6_pix_ce4",  32'(pix_ce4),  32'(c % 2));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
